// File: rtl/wasca_onchip_memory_arbiter.sv
// Round-robin two-master Avalon-MM arbiter in front of the single-port on-chip RAM.
// One access per cycle, out-of-range filtering, reads return exactly one cycle later.
module wasca_onchip_memory_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2560
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata,
    output logic                  oor_error
);
    localparam int              BE_W    = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    logic              w_req0, w_req1;
    logic              w_gnt0, w_gnt1, w_any_gnt;
    logic              w_sel_write, w_oor;
    logic [ADDR_W-1:0] w_sel_address;
    logic [BE_W-1:0]   w_sel_byteenable;
    logic [DATA_W-1:0] w_sel_writedata;

    logic              r_last_grant;   // 1 = m1 held the last grant
    logic              r_pend_valid, r_pend_id, r_pend_oor, r_oor_error;
    logic [ADDR_W-1:0] r_hold_address;
    logic [BE_W-1:0]   r_hold_byteenable;
    logic [DATA_W-1:0] r_hold_writedata;

    assign w_req0    = m0_read | m0_write;
    assign w_req1    = m1_read | m1_write;
    assign w_gnt0    = ~reset & w_req0 & (~w_req1 | r_last_grant);
    assign w_gnt1    = ~reset & w_req1 & ~w_gnt0;
    assign w_any_gnt = w_gnt0 | w_gnt1;

    assign w_sel_address    = w_gnt1 ? m1_address    : m0_address;
    assign w_sel_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
    assign w_sel_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
    assign w_sel_write      = w_gnt1 ? m1_write      : m0_write;
    assign w_oor            = {1'b0, w_sel_address} >= DEPTH_W;

    assign m0_waitrequest = reset | (w_req0 & ~w_gnt0);
    assign m1_waitrequest = reset | (w_req1 & ~w_gnt1);

    // Address/data lanes keep the last granted values while idle to avoid needless toggling.
    assign ram_address    = w_any_gnt ? w_sel_address    : r_hold_address;
    assign ram_byteenable = w_any_gnt ? w_sel_byteenable : r_hold_byteenable;
    assign ram_writedata  = w_any_gnt ? w_sel_writedata  : r_hold_writedata;
    assign ram_chipselect = w_any_gnt & ~w_oor;
    assign ram_write      = ram_chipselect & w_sel_write;
    assign ram_clken      = ~reset;

    assign m0_readdatavalid = r_pend_valid & ~r_pend_id;
    assign m1_readdatavalid = r_pend_valid &  r_pend_id;
    assign m0_readdata      = (m0_readdatavalid & ~r_pend_oor) ? ram_readdata : '0;
    assign m1_readdata      = (m1_readdatavalid & ~r_pend_oor) ? ram_readdata : '0;
    assign oor_error        = r_oor_error;

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_grant      <= 1'b1;
            r_pend_valid      <= 1'b0;
            r_pend_id         <= 1'b0;
            r_pend_oor        <= 1'b0;
            r_oor_error       <= 1'b0;
            r_hold_address    <= '0;
            r_hold_byteenable <= '0;
            r_hold_writedata  <= '0;
        end else begin
            r_pend_valid <= w_any_gnt & ~w_sel_write;
            if (w_any_gnt) begin
                r_last_grant      <= w_gnt1;
                r_pend_id         <= w_gnt1;
                r_pend_oor        <= w_oor;
                r_hold_address    <= w_sel_address;
                r_hold_byteenable <= w_sel_byteenable;
                r_hold_writedata  <= w_sel_writedata;
                if (w_oor) begin
                    r_oor_error <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_wasca_onchip_memory_arbiter.sv
// Bench for wasca_onchip_memory_arbiter: directed vector table, hand-written corner
// sequences, then randomized traffic checked against a transaction-level model.
module tb_wasca_onchip_memory_arbiter;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2560;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] m0_address, m1_address, ram_address;
    logic [3:0]  m0_byteenable, m1_byteenable, ram_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, ram_writedata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata, ram_readdata;
    logic        ram_chipselect, ram_write, ram_clken, oor_error;
    logic        ram_clear;

    int n_checks = 0;
    int n_err    = 0;

    wasca_onchip_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
        .oor_error(oor_error)
    );

    always #5 clk = ~clk;

    // Stand-in single-port RAM: registered q, read-before-write on the same edge.
    logic [31:0] ram_mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (ram_clear) begin
            for (int i = 0; i < DEPTH; i++) ram_mem[i] <= '0;
            ram_readdata <= '0;
        end else if (ram_clken && ram_chipselect) begin
            ram_readdata <= ram_mem[ram_address];
            if (ram_write)
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
        end
    end

    typedef struct {
        logic r0, w0; logic [11:0] a0; logic [31:0] d0; logic [3:0] be0;
        logic r1, w1; logic [11:0] a1; logic [31:0] d1; logic [3:0] be1;
        logic x_wait0, x_wait1, x_rdv0, x_rdv1;
        logic [31:0] x_rd0, x_rd1;
        logic x_cs, x_we;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mkv(
        input logic r0, input logic w0, input logic [11:0] a0, input logic [31:0] d0, input logic [3:0] be0,
        input logic r1, input logic w1, input logic [11:0] a1, input logic [31:0] d1, input logic [3:0] be1,
        input logic xw0, input logic xw1, input logic xv0, input logic xv1,
        input logic [31:0] xd0, input logic [31:0] xd1, input logic xcs, input logic xwe);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.be0 = be0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.be1 = be1;
        v.x_wait0 = xw0; v.x_wait1 = xw1; v.x_rdv0 = xv0; v.x_rdv1 = xv1;
        v.x_rd0 = xd0; v.x_rd1 = xd1; v.x_cs = xcs; v.x_we = xwe;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic xw0, input logic xw1,
                              input logic xv0, input logic xv1, input logic [31:0] xd0,
                              input logic [31:0] xd1, input logic xcs, input logic xwe);
        check({tag, " m0_waitrequest"},   32'(m0_waitrequest),   32'(xw0));
        check({tag, " m1_waitrequest"},   32'(m1_waitrequest),   32'(xw1));
        check({tag, " m0_readdatavalid"}, 32'(m0_readdatavalid), 32'(xv0));
        check({tag, " m1_readdatavalid"}, 32'(m1_readdatavalid), 32'(xv1));
        check({tag, " m0_readdata"},      m0_readdata,           xd0);
        check({tag, " m1_readdata"},      m1_readdata,           xd1);
        check({tag, " ram_chipselect"},   32'(ram_chipselect),   32'(xcs));
        check({tag, " ram_write"},        32'(ram_write),        32'(xwe));
    endtask

    task automatic drive(input int m, input logic rd, input logic wr, input logic [11:0] a,
                         input logic [31:0] d, input logic [3:0] be);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_writedata = d; m0_byteenable = be;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_writedata = d; m1_byteenable = be;
        end
    endtask

    task automatic idle();
        drive(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_req(input int m);
        int op;
        logic [11:0] a;
        op = int'($urandom_range(0, 4));
        a  = ($urandom_range(0, 9) < 9) ? 12'h100 + 12'($urandom_range(0, 7))
                                        : 12'hA00 + 12'($urandom_range(0, 'h5FF));
        drive(m, op == 2 || op == 4, op == 3 || op == 4, a, $urandom, 4'($urandom_range(0, 15)));
    endtask

    // Transaction-level reference state for the random phase.
    logic [31:0] model_mem [0:DEPTH-1];
    int          m_last, p_id, win;
    bit          m_oor, p_valid, hold0, hold1, req0, req1, w_wr, inr;
    logic [31:0] p_data, w_d;
    logic [11:0] w_a;
    logic [3:0]  w_be;
    logic        x_w0, x_w1, x_cs;

    initial begin
        reset = 1'b1;
        ram_clear = 1'b1;
        idle();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        tick(); tick();
        @(negedge clk);
        expect_out("reset", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("reset ram_clken", 32'(ram_clken), 32'h0);
        check("reset oor_error", 32'(oor_error), 32'h0);
        tick();
        reset = 1'b0;
        ram_clear = 1'b0;

        vecs[0]  = mkv(1'b0,1'b1,12'h010,32'hA5A51234,4'hF, 1'b0,1'b0,12'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1,1'b1);
        vecs[1]  = mkv(1'b1,1'b0,12'h010,32'h0,4'hF,        1'b0,1'b0,12'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1,1'b0);
        vecs[2]  = mkv(1'b0,1'b0,12'h000,32'h0,4'h0,        1'b0,1'b0,12'h000,32'h0,4'h0, 1'b0,1'b0,1'b1,1'b0,32'hA5A51234,32'h0,1'b0,1'b0);
        vecs[3]  = mkv(1'b0,1'b0,12'h000,32'h0,4'h0,        1'b0,1'b1,12'h020,32'h11223344,4'hF, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1,1'b1);
        vecs[4]  = mkv(1'b0,1'b0,12'h000,32'h0,4'h0,        1'b0,1'b1,12'h020,32'hFFFFFFFF,4'h2, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1,1'b1);
        vecs[5]  = mkv(1'b0,1'b0,12'h000,32'h0,4'h0,        1'b1,1'b0,12'h020,32'h0,4'hF, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1,1'b0);
        vecs[6]  = mkv(1'b0,1'b0,12'h000,32'h0,4'h0,        1'b0,1'b0,12'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b1,32'h0,32'h1122FF44,1'b0,1'b0);
        vecs[7]  = mkv(1'b0,1'b1,12'h001,32'h111,4'hF,      1'b0,1'b1,12'h002,32'h222,4'hF, 1'b0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b1,1'b1);
        vecs[8]  = mkv(1'b0,1'b0,12'h000,32'h0,4'h0,        1'b0,1'b1,12'h002,32'h222,4'hF, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b1,1'b1);
        vecs[9]  = mkv(1'b1,1'b0,12'h001,32'h0,4'hF,        1'b1,1'b0,12'h002,32'h0,4'hF, 1'b0,1'b1,1'b0,1'b0,32'h0,32'h0,1'b1,1'b0);
        vecs[10] = mkv(1'b1,1'b0,12'h001,32'h0,4'hF,        1'b1,1'b0,12'h002,32'h0,4'hF, 1'b1,1'b0,1'b1,1'b0,32'h111,32'h0,1'b1,1'b0);
        vecs[11] = mkv(1'b1,1'b0,12'h001,32'h0,4'hF,        1'b1,1'b0,12'h002,32'h0,4'hF, 1'b0,1'b1,1'b0,1'b1,32'h0,32'h222,1'b1,1'b0);
        vecs[12] = mkv(1'b1,1'b0,12'h001,32'h0,4'hF,        1'b1,1'b0,12'h002,32'h0,4'hF, 1'b1,1'b0,1'b1,1'b0,32'h111,32'h0,1'b1,1'b0);
        vecs[13] = mkv(1'b0,1'b0,12'h000,32'h0,4'h0,        1'b0,1'b0,12'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b1,32'h0,32'h222,1'b0,1'b0);
        vecs[14] = mkv(1'b0,1'b0,12'h000,32'h0,4'h0,        1'b0,1'b0,12'h000,32'h0,4'h0, 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,1'b0);

        foreach (vecs[i]) begin
            drive(0, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0, vecs[i].be0);
            drive(1, vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1, vecs[i].be1);
            @(negedge clk);
            expect_out($sformatf("vec%0d", i), vecs[i].x_wait0, vecs[i].x_wait1, vecs[i].x_rdv0,
                       vecs[i].x_rdv1, vecs[i].x_rd0, vecs[i].x_rd1, vecs[i].x_cs, vecs[i].x_we);
            if (i == 0) check("run ram_clken", 32'(ram_clken), 32'h1);
            tick();
        end
        @(negedge clk);
        check("idle ram_address holds", 32'(ram_address), 32'h002);
        tick();

        // Read and write of the same word in contention: the read goes first and sees old data.
        drive(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
        drive(1, 1'b0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF);
        @(negedge clk); expect_out("rw_same", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick(); drive(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        @(negedge clk); expect_out("rw_old", 1'b0, 1'b0, 1'b1, 1'b0, 32'hA5A51234, 32'h0, 1'b1, 1'b1);
        tick(); idle(); drive(0, 1'b1, 1'b0, 12'h010, 32'h0, 4'hF);
        @(negedge clk); expect_out("rw_reread", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick(); idle();
        @(negedge clk); expect_out("rw_new", 1'b0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
        tick();

        // Out-of-range read then write at the first address past the RAM.
        drive(0, 1'b1, 1'b0, 12'hA00, 32'h0, 4'hF);
        @(negedge clk); expect_out("oor_rd", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("oor_rd oor_error", 32'(oor_error), 32'h0);
        tick(); drive(0, 1'b0, 1'b1, 12'hA00, 32'h55, 4'hF);
        @(negedge clk); expect_out("oor_wr", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("oor_wr oor_error", 32'(oor_error), 32'h1);
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("oor sticky %0d", k), 32'(oor_error), 32'h1);
            tick();
        end

        // Reset lands while an m1 read is outstanding.
        drive(1, 1'b1, 1'b0, 12'h002, 32'h0, 4'hF);
        @(negedge clk); expect_out("pre_rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick(); reset = 1'b1; idle();
        @(negedge clk); expect_out("in_rst", 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("in_rst ram_clken", 32'(ram_clken), 32'h0);
        check("in_rst oor_error", 32'(oor_error), 32'h0);
        tick(); reset = 1'b0;
        @(negedge clk); expect_out("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(0, 1'b1, 1'b0, 12'h001, 32'h0, 4'hF);
        drive(1, 1'b1, 1'b0, 12'h002, 32'h0, 4'hF);
        @(negedge clk); expect_out("rst_first", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick(); drive(0, 1'b0, 1'b0, 12'h0, 32'h0, 4'h0);
        @(negedge clk); expect_out("rst_second", 1'b0, 1'b0, 1'b1, 1'b0, 32'h111, 32'h0, 1'b1, 1'b0);
        tick(); idle();
        @(negedge clk); expect_out("rst_drain", 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h222, 1'b0, 1'b0);
        tick();

        // Random traffic: model keeps whose turn it is, a shadow memory and one pending response.
        m_last = 1; m_oor = 1'b0; p_valid = 1'b0; p_id = 0; p_data = '0;
        hold0 = 1'b0; hold1 = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!hold0) rand_req(0);
            if (!hold1) rand_req(1);
            @(negedge clk);
            req0 = m0_read | m0_write;
            req1 = m1_read | m1_write;
            if (req0 && req1) win = 1 - m_last;
            else if (req0)    win = 0;
            else if (req1)    win = 1;
            else              win = -1;
            w_a  = (win == 1) ? m1_address    : m0_address;
            w_d  = (win == 1) ? m1_writedata  : m0_writedata;
            w_be = (win == 1) ? m1_byteenable : m0_byteenable;
            w_wr = (win == 1) ? m1_write      : m0_write;
            inr  = int'(w_a) < DEPTH;
            x_w0 = req0 && win != 0;
            x_w1 = req1 && win != 1;
            x_cs = win >= 0 && inr;
            expect_out($sformatf("rnd%0d", c), x_w0, x_w1, p_valid && p_id == 0, p_valid && p_id == 1,
                       (p_valid && p_id == 0) ? p_data : 32'h0, (p_valid && p_id == 1) ? p_data : 32'h0,
                       x_cs, x_cs && w_wr);
            check($sformatf("rnd%0d oor_error", c), 32'(oor_error), 32'(m_oor));
            p_valid = win >= 0 && !w_wr;
            p_id    = win;
            p_data  = inr ? model_mem[int'(w_a)] : 32'h0;
            if (win >= 0) begin
                m_last = win;
                if (!inr) m_oor = 1'b1;
                if (w_wr && inr)
                    for (int b = 0; b < 4; b++)
                        if (w_be[b]) model_mem[int'(w_a)][8*b +: 8] = w_d[8*b +: 8];
            end
            hold0 = x_w0;
            hold1 = x_w1;
            tick();
        end
        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/wasca_onchip_memory_arbiter.md
# wasca_onchip_memory_arbiter

Two-port Avalon-MM arbiter that shares the single-port 2560x32 on-chip RAM between the Nios CPU data master (m0) and the Saturn bus bridge (m1). It drives the RAM's address/byteenable/chipselect/write/writedata/clken pins and routes its unregistered read data back to the requester that issued the read. It grants one access per cycle with round-robin fairness, fully pipelined, and filters out-of-range addresses.

## Interface
- ADDR_W, 12, word address width on both masters and on the RAM
- DATA_W, 32, data width; byteenable width is DATA_W/8
- DEPTH, 2560, number of implemented RAM words; addresses >= DEPTH are out of range
- clk  in  1  single clock for the arbiter and the RAM
- reset  in  1  asynchronous, active-high reset
- mN_address  in  ADDR_W  word address (N = 0, 1, same set for each master)
- mN_byteenable  in  DATA_W/8  byte lanes for writes
- mN_read, mN_write  in  1  request strobes; both high at once is illegal and treated as write
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  DATA_W  read data, valid only with mN_readdatavalid
- mN_readdatavalid  out  1  one-cycle pulse carrying read data
- ram_address  out  ADDR_W, ram_byteenable  out  DATA_W/8, ram_writedata  out  DATA_W
- ram_chipselect, ram_write, ram_clken  out  1
- ram_readdata  in  DATA_W  RAM q, valid the cycle after the address is presented
- oor_error  out  1  sticky: an out-of-range access has occurred

## Operation
- Request: reqN = mN_read | mN_write. Grant is combinational from req0, req1 and the registered last_grant bit.
- Only one requesting: that master is granted. Both requesting: the master not in last_grant wins. last_grant updates on every grant edge; reset value 1 (m0 wins first contention).
- Granted master: mN_waitrequest = 0; RAM pins driven from its signals; ram_chipselect = 1, ram_write = mN_write.
- Ungranted requester: mN_waitrequest = 1; it must hold its signals (Avalon rule). Non-requesting master: waitrequest = 0 (don't-care).
- No grant: ram_chipselect = 0, ram_write = 0, ram_address/byteenable/writedata hold the last granted values.
- Out-of-range (address >= DEPTH): accepted (waitrequest 0), but ram_chipselect = 0 and ram_write = 0; oor_error set; a read still returns a readdatavalid pulse with readdata = 0.
- Read tracking: registers pend_valid, pend_id, pend_oor capture a granted read. The next cycle drives mN_readdatavalid = 1 for pend_id, with readdata = ram_readdata (or 0 if pend_oor). Both masters' readdata = 0 when not valid.
- oor_error is cleared only by reset.
- ram_clken = ~reset.

## Timing
- Reset state: last_grant = 1, pend_valid = 0, oor_error = 0, ram_chipselect = 0, ram_write = 0, both readdatavalid = 0, both readdata = 0.
- While reset is high, both waitrequest = 1.
- Read latency: exactly 1 cycle from the accepting edge (waitrequest low) to readdatavalid.
- Writes complete on the accepting edge; no response.
- Throughput: 1 access per cycle. Back-to-back reads from one master give readdatavalid on consecutive cycles. Reads alternate during contention.
- Read followed by a write to the same address: the read returns the old data (RAM order preserved).
- Reset asserted with a read pending: the pending read is dropped and no readdatavalid appears after reset is released.
- Contention fairness: a continuously requesting master waits at most 1 cycle.

## Test plan
- m0 writes 0xA5A5_1234 to address 0x010 with byteenable 0xF, then reads it -> waitrequest 0 both cycles; m0_readdatavalid 1 cycle after the read with 0xA5A5_1234; m1 outputs stay 0.
- m0 and m1 both read continuously from reset (addresses 0x001 and 0x002) -> grants m0, m1, m0, m1...; each readdatavalid at 50% rate with the correct data; each waitrequest high every other cycle.
- m1 writes 0x1122_3344, then writes 0xFFFF_FFFF with byteenable 0x2, then reads -> 0x1122_FF44.
- m0 reads address 0xA00 (2560) -> ram_chipselect 0; readdatavalid with 0x0000_0000; oor_error goes and stays 1 until reset.
- m1 read accepted, then reset asserted in the following cycle -> no m1_readdatavalid; all outputs at reset values; the first contention after release is won by m0.
- m0 read of address X and m1 write of address X both requested at the same time with last_grant = 1 -> m0 is granted first and receives the old value; the next read returns the new value.
